btb_assoc: RTL and testbench

Two-way set-associative, tagged branch target buffer for the dual-fetch front end. It predicts the next PC for both fetch slots (`if_pc0`, `if_pc0+4`) each cycle. It is trained by up to two retiring control instructions per cycle from the ROB. It stores full 62-bit word targets, tags and valid bits, and uses per-set LRU replacement.

---
 rtl/btb_pkg.sv | 44 ++++
 rtl/btb_set_update.sv | 63 ++++++
 rtl/btb_assoc.sv | 138 +++++++++++++
 tb/tb_btb_assoc.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared types and address helpers for the two-way branch target buffer.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package btb_pkg;

  // Associativity is fixed; the update and lookup logic is written for two ways.
  localparam int WAYS = 2;

  // Tags are held in a fixed-width field so the entry struct does not depend on
  // module parameters; the unused upper bits stay zero. TAG_BITS must be <= 32.
  localparam int MAX_TAG_BITS = 32;

  // Targets are word addresses: npc[63:2].
  localparam int TARGET_BITS = 62;

  typedef struct packed {
    logic                    valid;
    logic [MAX_TAG_BITS-1:0] tag;
    logic [TARGET_BITS-1:0]  target;
  } btb_entry_t;

  // One set: both ways plus the bit naming the way to replace next.
  typedef struct packed {
    btb_entry_t [WAYS-1:0] way;
    logic                  lru;
  } btb_set_t;

  // Set index = pc[log_sets+1:2]; the low two PC bits are ignored.
  function automatic logic [31:0] pc_index(input logic [63:0] pc, input int unsigned log_sets);
    logic [63:0] mask;
    mask = (64'd1 << log_sets) - 64'd1;
    return 32'((pc >> 2) & mask);
  endfunction

  // Tag = pc[log_sets+tag_bits+1 : log_sets+2]; bits above the tag are not kept.
  function automatic logic [MAX_TAG_BITS-1:0] pc_tag(input logic [63:0] pc,
                                                     input int unsigned log_sets,
                                                     input int unsigned tag_bits);
    logic [63:0] mask;
    mask = (64'd1 << tag_bits) - 64'd1;
    return MAX_TAG_BITS'((pc >> (log_sets + 2)) & mask);
  endfunction

endpackage

// File: rtl/btb_set_update.sv
// Applies one retiring control instruction to one BTB set (both ways plus lru).
// Latency: purely combinational, the caller registers the result.
// Backpressure: none; the update is always accepted when enable is high.
module btb_set_update
  import btb_pkg::*;
#(
  parameter int unsigned LOG_NUM_SETS = 8,
  parameter int unsigned TAG_BITS     = 12
) (
  input  logic        enable,
  input  logic [63:0] pc,
  input  logic        taken,
  input  logic [63:0] npc,
  input  btb_set_t    set_in,
  output btb_set_t    set_out
);

  logic [MAX_TAG_BITS-1:0] tag;
  logic [TARGET_BITS-1:0]  target;
  logic                    hit0;
  logic                    hit1;
  logic                    hit_way;
  logic                    alloc_way;

  assign tag    = pc_tag(pc, LOG_NUM_SETS, TAG_BITS);
  assign target = TARGET_BITS'(npc >> 2);

  // Classify the access (hit way / allocation victim) and build the new set.
  always_comb begin
    set_out   = set_in;
    hit0      = set_in.way[0].valid && (set_in.way[0].tag == tag);
    hit1      = set_in.way[1].valid && (set_in.way[1].tag == tag);
    // A double match cannot be produced by this logic, but way 0 wins if it appears.
    hit_way   = hit1 && !hit0;
    // Fill an invalid way first (way 0 before way 1), else evict the lru way.
    if (!set_in.way[0].valid) begin
      alloc_way = 1'b0;
    end else if (!set_in.way[1].valid) begin
      alloc_way = 1'b1;
    end else begin
      alloc_way = set_in.lru;
    end

    if (enable) begin
      if (hit0 || hit1) begin
        if (taken) begin
          set_out.way[hit_way].target = target;
          set_out.lru                 = ~hit_way;
        end else begin
          // A not-taken branch frees its way so it becomes the next victim.
          set_out.way[hit_way].valid = 1'b0;
          set_out.lru                = hit_way;
        end
      end else if (taken) begin
        set_out.way[alloc_way].valid  = 1'b1;
        set_out.way[alloc_way].tag    = tag;
        set_out.way[alloc_way].target = target;
        set_out.lru                   = ~alloc_way;
      end
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// Two-way set-associative BTB predicting targets for fetch slots if_pc0 and if_pc0+4.
// Latency: lookups are combinational and see same-cycle retire writes; storage updates on the clock edge.
// Backpressure: none; two retire ports and two lookups are accepted every cycle.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int unsigned NUM_SETS     = 256,
  parameter int unsigned LOG_NUM_SETS = 8,
  parameter int unsigned TAG_BITS     = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] if_pc0,
  input  logic        rob_retire_jump0,
  input  logic        rob_retire_jump1,
  input  logic        rob_retire_taken0,
  input  logic        rob_retire_taken1,
  input  logic [63:0] rob_retire_pc0,
  input  logic [63:0] rob_retire_pc1,
  input  logic [63:0] rob_cre_npc0,
  input  logic [63:0] rob_cre_npc1,
  output logic        if_pred_valid0,
  output logic        if_pred_valid1,
  output logic [63:0] if_pred_addr0,
  output logic [63:0] if_pred_addr1
);

  btb_set_t set_q [NUM_SETS];

  // Retires are ignored while reset is high so the clear is never partial.
  logic jump0;
  logic jump1;
  assign jump0 = rob_retire_jump0 & ~reset;
  assign jump1 = rob_retire_jump1 & ~reset;

  logic [LOG_NUM_SETS-1:0] ridx0;
  logic [LOG_NUM_SETS-1:0] ridx1;
  logic [LOG_NUM_SETS-1:0] lidx0;
  logic [LOG_NUM_SETS-1:0] lidx1;
  logic [MAX_TAG_BITS-1:0] ltag0;
  logic [MAX_TAG_BITS-1:0] ltag1;
  logic [63:0]             if_pc1;

  // Slot 1 index/tag come from the incremented PC, so the top set wraps to set 0.
  assign if_pc1 = if_pc0 + 64'd4;
  assign ridx0  = LOG_NUM_SETS'(pc_index(rob_retire_pc0, LOG_NUM_SETS));
  assign ridx1  = LOG_NUM_SETS'(pc_index(rob_retire_pc1, LOG_NUM_SETS));
  assign lidx0  = LOG_NUM_SETS'(pc_index(if_pc0, LOG_NUM_SETS));
  assign lidx1  = LOG_NUM_SETS'(pc_index(if_pc1, LOG_NUM_SETS));
  assign ltag0  = pc_tag(if_pc0, LOG_NUM_SETS, TAG_BITS);
  assign ltag1  = pc_tag(if_pc1, LOG_NUM_SETS, TAG_BITS);

  btb_set_t upd0_in;
  btb_set_t upd0_out;
  btb_set_t upd1_in;
  btb_set_t upd1_out;
  btb_set_t look0;
  btb_set_t look1;

  // Port 1 operates on port 0's result when both retire into the same set.
  always_comb begin
    upd0_in = set_q[ridx0];
    upd1_in = (jump0 && (ridx1 == ridx0)) ? upd0_out : set_q[ridx1];
  end

  btb_set_update #(
    .LOG_NUM_SETS(LOG_NUM_SETS),
    .TAG_BITS    (TAG_BITS)
  ) u_update0 (
    .enable (jump0),
    .pc     (rob_retire_pc0),
    .taken  (rob_retire_taken0),
    .npc    (rob_cre_npc0),
    .set_in (upd0_in),
    .set_out(upd0_out)
  );

  btb_set_update #(
    .LOG_NUM_SETS(LOG_NUM_SETS),
    .TAG_BITS    (TAG_BITS)
  ) u_update1 (
    .enable (jump1),
    .pc     (rob_retire_pc1),
    .taken  (rob_retire_taken1),
    .npc    (rob_cre_npc1),
    .set_in (upd1_in),
    .set_out(upd1_out)
  );

  // Lookups read the next-state set: registered contents overridden by this
  // cycle's retire results (port 1 last, since it already includes port 0).
  always_comb begin
    look0 = set_q[lidx0];
    if (jump0 && (lidx0 == ridx0)) look0 = upd0_out;
    if (jump1 && (lidx0 == ridx1)) look0 = upd1_out;
    look1 = set_q[lidx1];
    if (jump0 && (lidx1 == ridx0)) look1 = upd0_out;
    if (jump1 && (lidx1 == ridx1)) look1 = upd1_out;
  end

  // Tag compare for one slot; returns {hit, predicted byte address}, way 0 first.
  function automatic logic [64:0] probe(input btb_set_t s, input logic [MAX_TAG_BITS-1:0] tag);
    if (s.way[0].valid && (s.way[0].tag == tag)) begin
      return {1'b1, s.way[0].target, 2'b00};
    end else if (s.way[1].valid && (s.way[1].tag == tag)) begin
      return {1'b1, s.way[1].target, 2'b00};
    end
    return 65'd0;
  endfunction

  // Predictions are forced to zero during reset, when the array may hold stale data.
  always_comb begin
    if (reset) begin
      {if_pred_valid0, if_pred_addr0} = 65'd0;
      {if_pred_valid1, if_pred_addr1} = 65'd0;
    end else begin
      {if_pred_valid0, if_pred_addr0} = probe(look0, ltag0);
      {if_pred_valid1, if_pred_addr1} = probe(look1, ltag1);
    end
  end

  // Reset clears every valid and lru bit; otherwise commit port 0 then port 1
  // (port 1's write wins on a shared set, and it already contains port 0's update).
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < int'(NUM_SETS); s++) begin
        set_q[s].lru <= 1'b0;
        for (int w = 0; w < WAYS; w++) begin
          set_q[s].way[w].valid <= 1'b0;
        end
      end
    end else begin
      if (jump0) set_q[ridx0] <= upd0_out;
      if (jump1) set_q[ridx1] <= upd1_out;
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc: expected predictions are queued per cycle and compared after sampling.
// Latency: stimulus applied 1ns after the rising edge, outputs sampled on the falling edge of the same cycle.
// Backpressure: none; one row of stimulus per clock.
module tb_btb_assoc;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] if_pc0;
  logic        rob_retire_jump0, rob_retire_jump1;
  logic        rob_retire_taken0, rob_retire_taken1;
  logic [63:0] rob_retire_pc0, rob_retire_pc1;
  logic [63:0] rob_cre_npc0, rob_cre_npc1;
  logic        if_pred_valid0, if_pred_valid1;
  logic [63:0] if_pred_addr0, if_pred_addr1;

  typedef struct packed {
    logic        v0;
    logic [63:0] a0;
    logic        v1;
    logic [63:0] a1;
  } obs_t;

  obs_t exp_q[$];
  obs_t obs_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  btb_assoc #(
    .NUM_SETS    (256),
    .LOG_NUM_SETS(8),
    .TAG_BITS    (12)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .if_pc0           (if_pc0),
    .rob_retire_jump0 (rob_retire_jump0),
    .rob_retire_jump1 (rob_retire_jump1),
    .rob_retire_taken0(rob_retire_taken0),
    .rob_retire_taken1(rob_retire_taken1),
    .rob_retire_pc0   (rob_retire_pc0),
    .rob_retire_pc1   (rob_retire_pc1),
    .rob_cre_npc0     (rob_cre_npc0),
    .rob_cre_npc1     (rob_cre_npc1),
    .if_pred_valid0   (if_pred_valid0),
    .if_pred_valid1   (if_pred_valid1),
    .if_pred_addr0    (if_pred_addr0),
    .if_pred_addr1    (if_pred_addr1)
  );

  // One clock of stimulus: drive, queue expectation, sample at negedge, advance.
  task automatic cyc(input logic rst,
                     input logic j0, input logic t0, input logic [63:0] p0, input logic [63:0] n0,
                     input logic j1, input logic t1, input logic [63:0] p1, input logic [63:0] n1,
                     input logic [63:0] ifpc,
                     input logic ev0, input logic [63:0] ea0, input logic ev1, input logic [63:0] ea1);
    reset = rst;
    rob_retire_jump0 = j0; rob_retire_taken0 = t0; rob_retire_pc0 = p0; rob_cre_npc0 = n0;
    rob_retire_jump1 = j1; rob_retire_taken1 = t1; rob_retire_pc1 = p1; rob_cre_npc1 = n1;
    if_pc0 = ifpc;
    exp_q.push_back('{v0: ev0, a0: ea0, v1: ev1, a1: ea1});
    @(negedge clock);
    obs_q.push_back('{v0: if_pred_valid0, a0: if_pred_addr0, v1: if_pred_valid1, a1: if_pred_addr1});
    @(posedge clock);
    #1;
  endtask

  // Lookup-only cycle.
  task automatic lk(input logic [63:0] ifpc,
                    input logic ev0, input logic [63:0] ea0, input logic ev1, input logic [63:0] ea1);
    cyc(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0, ifpc, ev0, ea0, ev1, ea1);
  endtask

  // Single retire on port 0 plus a lookup in the same cycle.
  task automatic r0(input logic t0, input logic [63:0] p0, input logic [63:0] n0, input logic [63:0] ifpc,
                    input logic ev0, input logic [63:0] ea0, input logic ev1, input logic [63:0] ea1);
    cyc(1'b0, 1'b1, t0, p0, n0, 1'b0, 1'b0, 64'd0, 64'd0, ifpc, ev0, ea0, ev1, ea1);
  endtask

  task automatic test_reset();
    int row = 0;
    obs_t e, o;
    // Retire during reset must be ignored; outputs forced low.
    cyc(1'b1, 1'b1, 1'b1, 64'h1000, 64'h2000, 1'b0, 1'b0, 64'd0, 64'd0, 64'h1000, 1'b0, 64'd0, 1'b0, 64'd0);
    lk(64'h1000, 1'b0, 64'd0, 1'b0, 64'd0);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL test_reset row %0d: got v0=%b a0=%h v1=%b a1=%h, expected v0=%b a0=%h v1=%b a1=%h",
                 row, o.v0, o.a0, o.v1, o.a1, e.v0, e.a0, e.v1, e.a1);
      end
      row++;
    end
  endtask

  task automatic test_bypass();
    int row = 0;
    obs_t e, o;
    r0(1'b1, 64'h1000, 64'h2000, 64'h1000, 1'b1, 64'h2000, 1'b0, 64'd0);  // same-cycle bypass
    lk(64'h0FFC, 1'b0, 64'd0, 1'b1, 64'h2000);                             // hit on slot 1
    lk(64'h1000, 1'b1, 64'h2000, 1'b0, 64'd0);                             // from registers
    r0(1'b1, 64'h1400, 64'h7000, 64'h1400, 1'b1, 64'h7000, 1'b0, 64'd0);
    lk(64'h13FC, 1'b0, 64'd0, 1'b1, 64'h7000);                             // slot 1 wraps to set 0, tag 5
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL test_bypass row %0d: got v0=%b a0=%h v1=%b a1=%h, expected v0=%b a0=%h v1=%b a1=%h",
                 row, o.v0, o.a0, o.v1, o.a1, e.v0, e.a0, e.v1, e.a1);
      end
      row++;
    end
  endtask

  task automatic test_eviction();
    int row = 0;
    obs_t e, o;
    // Set 5: A tag 1, B tag 2, C tag 3, D tag 4.
    r0(1'b1, 64'h414,  64'hA000, 64'h414,  1'b1, 64'hA000, 1'b0, 64'd0);
    r0(1'b1, 64'h814,  64'hB000, 64'h814,  1'b1, 64'hB000, 1'b0, 64'd0);
    r0(1'b1, 64'hC14,  64'hC000, 64'hC14,  1'b1, 64'hC000, 1'b0, 64'd0);  // evicts A
    lk(64'h414, 1'b0, 64'd0,    1'b0, 64'd0);
    lk(64'h814, 1'b1, 64'hB000, 1'b0, 64'd0);
    lk(64'hC14, 1'b1, 64'hC000, 1'b0, 64'd0);
    r0(1'b0, 64'h814,  64'h0,    64'h814,  1'b0, 64'd0,    1'b0, 64'd0);  // B invalidated
    r0(1'b1, 64'h1014, 64'hD000, 64'h1014, 1'b1, 64'hD000, 1'b0, 64'd0);  // D takes B's way
    lk(64'hC10, 1'b0, 64'd0, 1'b1, 64'hC000);                              // C survives
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL test_eviction row %0d: got v0=%b a0=%h v1=%b a1=%h, expected v0=%b a0=%h v1=%b a1=%h",
                 row, o.v0, o.a0, o.v1, o.a1, e.v0, e.a0, e.v1, e.a1);
      end
      row++;
    end
  endtask

  task automatic test_back_to_back();
    int row = 0;
    obs_t e, o;
    cyc(1'b0, 1'b1, 1'b1, 64'h3000, 64'h4000, 1'b1, 1'b1, 64'h3000, 64'h5000, 64'h3000,
        1'b1, 64'h5000, 1'b0, 64'd0);
    lk(64'h3000, 1'b1, 64'h5000, 1'b0, 64'd0);
    cyc(1'b0, 1'b1, 1'b1, 64'h424, 64'h6000, 1'b1, 1'b1, 64'h824, 64'h6100, 64'h424,
        1'b1, 64'h6000, 1'b0, 64'd0);
    lk(64'h824, 1'b1, 64'h6100, 1'b0, 64'd0);
    lk(64'h424, 1'b1, 64'h6000, 1'b0, 64'd0);
    // Port 0 allocates, port 1 same pc not taken: port 1 outcome is final.
    cyc(1'b0, 1'b1, 1'b1, 64'h434, 64'h6200, 1'b1, 1'b0, 64'h434, 64'h0, 64'h434,
        1'b0, 64'd0, 1'b0, 64'd0);
    // Inactive ports carry junk that must be ignored.
    cyc(1'b0, 1'b0, 1'b1, 64'h434, 64'h9990, 1'b0, 1'b1, 64'h434, 64'h9998, 64'h434,
        1'b0, 64'd0, 1'b0, 64'd0);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL test_back_to_back row %0d: got v0=%b a0=%h v1=%b a1=%h, expected v0=%b a0=%h v1=%b a1=%h",
                 row, o.v0, o.a0, o.v1, o.a1, e.v0, e.a0, e.v1, e.a1);
      end
      row++;
    end
  endtask

  task automatic test_alias();
    int row = 0;
    obs_t e, o;
    lk(64'hC24,               1'b0, 64'd0,    1'b0, 64'd0);  // tag 3 at set 9: miss
    lk(64'h400824,            1'b1, 64'h6100, 1'b0, 64'd0);  // bits above tag differ: aliases
    lk(64'hFFFF000000000824,  1'b1, 64'h6100, 1'b0, 64'd0);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL test_alias row %0d: got v0=%b a0=%h v1=%b a1=%h, expected v0=%b a0=%h v1=%b a1=%h",
                 row, o.v0, o.a0, o.v1, o.a1, e.v0, e.a0, e.v1, e.a1);
      end
      row++;
    end
  endtask

  task automatic test_mid_reset();
    int row = 0;
    obs_t e, o;
    cyc(1'b1, 1'b1, 1'b1, 64'h2000, 64'h8000, 1'b0, 1'b0, 64'd0, 64'd0, 64'h824,
        1'b0, 64'd0, 1'b0, 64'd0);
    lk(64'h824,  1'b0, 64'd0, 1'b0, 64'd0);
    lk(64'hC10,  1'b0, 64'd0, 1'b0, 64'd0);
    lk(64'h2000, 1'b0, 64'd0, 1'b0, 64'd0);
    lk(64'h3000, 1'b0, 64'd0, 1'b0, 64'd0);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL test_mid_reset row %0d: got v0=%b a0=%h v1=%b a1=%h, expected v0=%b a0=%h v1=%b a1=%h",
                 row, o.v0, o.a0, o.v1, o.a1, e.v0, e.a0, e.v1, e.a1);
      end
      row++;
    end
  endtask

  initial begin
    reset = 1'b1;
    if_pc0 = 64'd0;
    rob_retire_jump0 = 1'b0; rob_retire_jump1 = 1'b0;
    rob_retire_taken0 = 1'b0; rob_retire_taken1 = 1'b0;
    rob_retire_pc0 = 64'd0; rob_retire_pc1 = 64'd0;
    rob_cre_npc0 = 64'd0; rob_cre_npc1 = 64'd0;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_bypass();
    test_eviction();
    test_back_to_back();
    test_alias();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
